// File: rtl/mod_74x_counter_bank_if.sv
// mod_74x_counter_bank_if: control, data and status bundle for the counter bank
//   master: drives CLR_CH, EN, UP, LOAD, D; observes Q, TC, OVF
//   slave : the counter bank itself
interface mod_74x_counter_bank_if #(
    parameter int WIDTH = 4,
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] CLR_CH, EN, UP, LOAD, TC, OVF;
    logic [CHANNELS*WIDTH-1:0] D, Q;
    modport master (output CLR_CH, EN, UP, LOAD, D, input Q, TC, OVF);
    modport slave (input CLR_CH, EN, UP, LOAD, D, output Q, TC, OVF);
endinterface

// File: rtl/mod_74x_counter_bank.sv
// mod_74x_counter_bank: bank of up/down counters with load, clears, terminal count and sticky wrap flag
//   CLK      falling-edge clock for all state
//   CLR      global synchronous clear, active-high
//   bus      CLR_CH/EN/UP/LOAD/D per-channel controls; Q counts, TC terminal count, OVF sticky wrap
module mod_74x_counter_bank #(
    parameter int WIDTH = 4,
    parameter int CHANNELS = 2,
    parameter int CASCADE = 0
) (
    input logic CLK,
    input logic CLR,
    mod_74x_counter_bank_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    logic [CHANNELS*WIDTH-1:0] q = '0;
    logic [CHANNELS-1:0] ovf = '0;
    logic [CHANNELS-1:0] ce, tc;
    logic carry;
    logic [WIDTH-1:0] v;
    // carry ripples the previous channel's TC so cascaded channels only step on a lower wrap
    always_comb begin
        ce = '0;
        tc = '0;
        carry = 1'b1;
        v = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            v = q[i*WIDTH +: WIDTH];
            ce[i] = bus.EN[i] & (CASCADE == 0 || carry);
            tc[i] = ce[i] & (bus.UP[i] ? &v : ~|v);
            carry = tc[i];
        end
    end
    always_ff @(negedge CLK) begin
        if (CLR) begin
            q <= '0;
            ovf <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.CLR_CH[i] | bus.LOAD[i]) begin
                    q[i*WIDTH +: WIDTH] <= bus.CLR_CH[i] ? '0 : bus.D[i*WIDTH +: WIDTH];
                    ovf[i] <= 1'b0;
                end else if (ce[i]) begin
                    q[i*WIDTH +: WIDTH] <= bus.UP[i] ? q[i*WIDTH +: WIDTH] + ONE : q[i*WIDTH +: WIDTH] - ONE;
                    ovf[i] <= ovf[i] | tc[i];
                end
            end
        end
    end
    assign bus.Q = q;
    assign bus.OVF = ovf;
    assign bus.TC = tc;
endmodule

// File: tb/tb_mod_74x_counter_bank.sv
// tb_mod_74x_counter_bank: vector table, corner sequences and randomized model check for the counter bank
module tb_mod_74x_counter_bank;
    typedef struct {
        bit c;
        bit clr;
        bit [1:0] cc, en, up, ld;
        bit [7:0] d, q;
        bit [1:0] ovf, tc;
    } vec_t;

    logic CLK = 1'b0;
    logic clr_a = 1'b0, clr_c = 1'b0, clr_r = 1'b0, clr_k = 1'b0;
    int nvec = 0;
    int nbad = 0;
    int unsigned mq [4];
    bit mo [4];
    vec_t tbl [$];

    always #5 CLK = ~CLK;

    mod_74x_counter_bank_if #(.WIDTH(4), .CHANNELS(2)) ia ();
    mod_74x_counter_bank_if #(.WIDTH(4), .CHANNELS(2)) ic ();
    mod_74x_counter_bank_if #(.WIDTH(8), .CHANNELS(4)) ir ();
    mod_74x_counter_bank_if #(.WIDTH(8), .CHANNELS(4)) ik ();

    mod_74x_counter_bank #(.WIDTH(4), .CHANNELS(2), .CASCADE(0)) dut_a (.CLK(CLK), .CLR(clr_a), .bus(ia));
    mod_74x_counter_bank #(.WIDTH(4), .CHANNELS(2), .CASCADE(1)) dut_c (.CLK(CLK), .CLR(clr_c), .bus(ic));
    mod_74x_counter_bank #(.WIDTH(8), .CHANNELS(4), .CASCADE(0)) dut_r (.CLK(CLK), .CLR(clr_r), .bus(ir));
    mod_74x_counter_bank #(.WIDTH(8), .CHANNELS(4), .CASCADE(1)) dut_k (.CLK(CLK), .CLR(clr_k), .bus(ik));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        clr_a = 0; clr_c = 0; clr_r = 0; clr_k = 0;
        ia.CLR_CH = '0; ia.EN = '0; ia.UP = '0; ia.LOAD = '0; ia.D = '0;
        ic.CLR_CH = '0; ic.EN = '0; ic.UP = '0; ic.LOAD = '0; ic.D = '0;
        ir.CLR_CH = '0; ir.EN = '0; ir.UP = '0; ir.LOAD = '0; ir.D = '0;
        ik.CLR_CH = '0; ik.EN = '0; ik.UP = '0; ik.LOAD = '0; ik.D = '0;
    endtask

    function automatic vec_t mk(input bit c, input bit clr, input bit [1:0] cc, input bit [1:0] en,
                                input bit [1:0] up, input bit [1:0] ld, input bit [7:0] d,
                                input bit [7:0] q, input bit [1:0] ovf, input bit [1:0] tc);
        vec_t v;
        v.c = c; v.clr = clr; v.cc = cc; v.en = en; v.up = up; v.ld = ld;
        v.d = d; v.q = q; v.ovf = ovf; v.tc = tc;
        return v;
    endfunction

    // called just after a falling edge: drive, check TC before the next edge, check Q/OVF after it
    task automatic apply(input vec_t v);
        idle();
        if (v.c) begin
            clr_c = v.clr; ic.CLR_CH = v.cc; ic.EN = v.en; ic.UP = v.up; ic.LOAD = v.ld; ic.D = v.d;
        end else begin
            clr_a = v.clr; ia.CLR_CH = v.cc; ia.EN = v.en; ia.UP = v.up; ia.LOAD = v.ld; ia.D = v.d;
        end
        #2;
        chk(v.c ? "tc_casc" : "tc", 32'(v.c ? ic.TC : ia.TC), 32'(v.tc));
        @(negedge CLK);
        #1;
        chk(v.c ? "q_casc" : "q", 32'(v.c ? ic.Q : ia.Q), 32'(v.q));
        chk(v.c ? "ovf_casc" : "ovf", 32'(v.c ? ic.OVF : ia.OVF), 32'(v.ovf));
        nvec++;
    endtask

    task automatic rand_run(input bit casc, input int n);
        bit [3:0] cc, en, up, ld, etc, eo;
        bit [31:0] d, eq;
        bit clr, carry, ce, t;
        up = 4'hF;
        for (int k = 0; k < n; k++) begin
            clr = ($urandom_range(63) == 0);
            for (int i = 0; i < 4; i++) begin
                cc[i] = ($urandom_range(15) == 0);
                ld[i] = ($urandom_range(7) == 0);
                en[i] = ($urandom_range(3) != 0);
                case ($urandom_range(3))
                    0: d[8*i +: 8] = 8'hFF;
                    1: d[8*i +: 8] = 8'h00;
                    default: d[8*i +: 8] = 8'($urandom);
                endcase
            end
            if (!casc) up = 4'($urandom);
            else if ($urandom_range(15) == 0) up = ~up;
            // reference: a channel steps when enabled (and, chained, when the one below sits at its end)
            carry = 1'b1;
            etc = '0;
            eq = '0;
            eo = '0;
            for (int i = 0; i < 4; i++) begin
                ce = en[i] && (!casc || carry);
                t = ce && (up[i] ? mq[i] == 255 : mq[i] == 0);
                etc[i] = t;
                carry = t;
                if (clr || cc[i]) begin
                    mq[i] = 0; mo[i] = 0;
                end else if (ld[i]) begin
                    mq[i] = d[8*i +: 8]; mo[i] = 0;
                end else if (ce) begin
                    mq[i] = (mq[i] + (up[i] ? 1 : 255)) % 256;
                    mo[i] = mo[i] | t;
                end
                eq[8*i +: 8] = 8'(mq[i]);
                eo[i] = mo[i];
            end
            idle();
            if (casc) begin
                clr_k = clr; ik.CLR_CH = cc; ik.EN = en; ik.UP = up; ik.LOAD = ld; ik.D = d;
            end else begin
                clr_r = clr; ir.CLR_CH = cc; ir.EN = en; ir.UP = up; ir.LOAD = ld; ir.D = d;
            end
            #2;
            chk(casc ? "rnd_tc_casc" : "rnd_tc", 32'(casc ? ik.TC : ir.TC), 32'(etc));
            @(negedge CLK);
            #1;
            chk(casc ? "rnd_q_casc" : "rnd_q", casc ? ik.Q : ir.Q, eq);
            chk(casc ? "rnd_ovf_casc" : "rnd_ovf", 32'(casc ? ik.OVF : ir.OVF), 32'(eo));
            nvec++;
        end
    endtask

    initial begin
        idle();
        for (int i = 0; i < 4; i++) begin
            mq[i] = 0;
            mo[i] = 0;
        end
        #1;
        chk("powerup_q", 32'(ia.Q), 32'h0);
        chk("powerup_ovf", 32'(ia.OVF), 32'h0);
        @(negedge CLK);
        #1;
        //            c clr cc en up ld  d      q      ovf tc
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3, 3, 0, 8'h00, 8'h11, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h0F, 8'h1F, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 8'h03, 8'h13, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h00, 8'h14, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 8'h00, 8'h04, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2, 0, 0, 8'h00, 8'hF4, 2, 2));
        tbl.push_back(mk(0, 0, 0, 2, 0, 2, 8'h90, 8'h94, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3, 0, 0, 8'h00, 8'h83, 0, 0));
        tbl.push_back(mk(0, 0, 2, 3, 3, 0, 8'h00, 8'h04, 0, 0));
        tbl.push_back(mk(0, 0, 2, 3, 0, 0, 8'h00, 8'h03, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h0F, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h0F, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 1, 1));
        tbl.push_back(mk(0, 1, 0, 3, 3, 3, 8'hFF, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 8'h05, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3, 3, 2, 8'h70, 8'h71, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 8'h0F, 8'h0F, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3, 3, 0, 8'h00, 8'h10, 1, 1));
        tbl.push_back(mk(1, 0, 0, 3, 0, 0, 8'h00, 8'h0F, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 8'hFF, 8'hFF, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3, 3, 0, 8'h00, 8'h00, 3, 3));
        tbl.push_back(mk(1, 0, 0, 3, 3, 1, 8'h0F, 8'h0F, 2, 0));
        tbl.push_back(mk(1, 0, 0, 2, 3, 0, 8'h00, 8'h0F, 2, 0));
        tbl.push_back(mk(1, 0, 1, 3, 3, 0, 8'h00, 8'h10, 2, 1));
        // channel 0 free-running up from a clear: 1..15, wrap to 0, then 1
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        for (int k = 1; k <= 17; k++)
            tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h00, 8'(k % 16), (k >= 16) ? 2'd1 : 2'd0, (k == 16) ? 2'd1 : 2'd0));
        foreach (tbl[i]) apply(tbl[i]);
        // CLR held between edges must not disturb Q; it lands on the next edge, counting restarts at 0
        idle();
        clr_a = 1'b1;
        #7;
        chk("clr_no_edge_q", 32'(ia.Q), 32'h01);
        @(negedge CLK);
        #1;
        chk("clr_edge_q", 32'(ia.Q), 32'h00);
        chk("clr_edge_ovf", 32'(ia.OVF), 32'h0);
        nvec++;
        idle();
        ia.EN = 2'b01;
        ia.UP = 2'b01;
        @(negedge CLK);
        #1;
        chk("resume_q", 32'(ia.Q), 32'h01);
        nvec++;
        rand_run(1'b0, 10000);
        for (int i = 0; i < 4; i++) begin
            mq[i] = 0;
            mo[i] = 0;
        end
        rand_run(1'b1, 3000);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/mod_74x_counter_bank.md
MOD_74X_COUNTER_BANK -- requirements
Module: mod_74x_counter_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, bits per counter channel (legal range 1..32).
REQ-002 The block SHALL have parameter CHANNELS, default 2, number of independent counter channels (legal range 1..8).
REQ-003 The block SHALL have parameter CASCADE, default 0; when 1, the channels chain into one CHANNELS*WIDTH-bit counter, with channel 0 least significant.
REQ-004 The block SHALL have port CLK, input, 1 bit, the single clock; all state SHALL update on its falling edge only.
REQ-005 The block SHALL have port CLR, input, 1 bit, a global reset that is synchronous and active-high.
REQ-006 The block SHALL have port CLR_CH, input, CHANNELS bits, per-channel clear, synchronous and active-high.
REQ-007 The block SHALL have port EN, input, CHANNELS bits, per-channel count enable, active-high.
REQ-008 The block SHALL have port UP, input, CHANNELS bits, per-channel direction: 1 = up, 0 = down.
REQ-009 The block SHALL have port LOAD, input, CHANNELS bits, per-channel synchronous parallel load, active-high.
REQ-010 The block SHALL have port D, input, CHANNELS*WIDTH bits; channel i load data is D[i*WIDTH +: WIDTH].
REQ-011 The block SHALL have port Q, output, CHANNELS*WIDTH bits, registered counts; channel i occupies Q[i*WIDTH +: WIDTH].
REQ-012 The block SHALL have port TC, output, CHANNELS bits, per-channel terminal count, combinational.
REQ-013 The block SHALL have port OVF, output, CHANNELS bits, per-channel sticky wrap flag, registered.

Function
REQ-014 Effective count enable SHALL be: ce[i] = EN[i] AND (CASCADE==0 OR i==0 OR TC[i-1]).
REQ-015 TC[i] SHALL be: ce[i] AND ((UP[i] AND Q_i == all-ones) OR (!UP[i] AND Q_i == 0)).
REQ-016 Per-channel update priority at each falling CLK edge SHALL be: CLR > CLR_CH[i] > LOAD[i] > count (ce[i]) > hold.
REQ-017 On CLR_CH[i]=1 (CLR=0), Q_i SHALL become 0 and OVF[i] SHALL become 0; other channels SHALL be unaffected.
REQ-018 On LOAD[i]=1, Q_i SHALL become D_i and OVF[i] SHALL become 0, regardless of ce[i]; the load value SHALL be visible on Q one edge later (latency 1).
REQ-019 On count, Q_i SHALL become Q_i+1 (UP) or Q_i-1 (down), modulo 2^WIDTH: all-ones+1 wraps to 0, and 0-1 wraps to all-ones.
REQ-020 When a channel counts while TC[i]=1 (a wrap), OVF[i] SHALL be set to 1 and SHALL remain 1 until CLR, CLR_CH[i] or LOAD[i].
REQ-021 When LOAD[i] coincides with a would-be wrap, load SHALL win and OVF[i] SHALL be 0.
REQ-022 In CASCADE=1, a LOAD or clear of channel i SHALL NOT by itself advance channel i+1; channel i+1 advances only on a ce[i+1] edge.
REQ-023 In CASCADE=1, the upper channels SHALL follow their own UP bits; mixed directions are legal but undefined as a composite count, and the bench SHALL drive uniform UP.
REQ-024 Outputs SHALL NOT glitch between edges except TC, which follows EN, UP and Q combinationally.

Reset
REQ-025 While CLR=1 at a falling CLK edge, all Q SHALL be 0 and all OVF SHALL be 0, overriding LOAD, CLR_CH and EN.
REQ-026 CLR SHALL NOT act asynchronously; with CLR=1 and no CLK edge, Q SHALL hold.
REQ-027 A CLR asserted mid-count SHALL take effect at the next falling edge; counting SHALL resume from 0 on the first edge after CLR deasserts.
REQ-028 After power-up and before the first CLR, Q and OVF SHALL be initialised to 0.

Verification (WIDTH=4, CHANNELS=2 unless stated)
REQ-029 CLR=1 for one edge, then EN=2'b01, UP=2'b01, 17 edges -> Q_0 sequence 1..15,0,1; OVF[0]=1 after the 16th edge; Q_1=0, OVF[1]=0.
REQ-030 Q_1=0, EN[1]=1, UP[1]=0, one edge -> Q_1=4'hF and OVF[1]=1; then LOAD[1]=1, D_1=4'h9 -> Q_1=9, OVF[1]=0.
REQ-031 Q_0=4'hF, UP[0]=1, EN[0]=1, LOAD[0]=1, D_0=3 on the same edge -> Q_0=3, OVF[0]=0.
REQ-032 CASCADE=1, all UP=1, EN=2'b11, Q=8'h0F, one edge -> Q=8'h10; from Q=8'hFF, one edge -> Q=8'h00 and OVF=2'b11.
REQ-033 Counting with CLR_CH=2'b10 held -> Q_1 stays 0 while Q_0 keeps counting; CLR=1 together with LOAD=2'b11 -> Q=0, OVF=0.
REQ-034 CHANNELS=4, WIDTH=8, random EN/UP/LOAD/CLR_CH for 10k edges -> Q, TC and OVF match the reference model every edge.
